frame_game_timer: RTL

Parametrised frame-driven game timer: counts `startOfFrame` strobes, emits a one-cycle pulse per elapsed second, and keeps a multi-digit BCD seconds value counting up or down. Down mode supports loadable round time and expiry. Pause and stop freeze time. Sits between the VGA frame-strobe source and the score/HUD drawing and game-control logic.

---
 rtl/frame_game_timer_if.sv | 29 ++
 rtl/frame_game_timer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/frame_game_timer_if.sv
// Control inputs and status outputs of frame_game_timer; master drives the commands,
// slave is the timer itself.
interface frame_game_timer_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  startOfFrame;
  logic                  pause;
  logic                  start;
  logic                  stop;
  logic                  load;
  logic [4*DIGITS-1:0]   loadBcd;
  logic                  countDown;
  logic                  secPassed;
  logic [4*DIGITS-1:0]   secondsBcd;
  logic                  expired;
  logic                  expiredPulse;
  logic                  running;
  logic                  warn;

  modport master (
    output startOfFrame, pause, start, stop, load, loadBcd, countDown,
    input  secPassed, secondsBcd, expired, expiredPulse, running, warn
  );

  modport slave (
    input  startOfFrame, pause, start, stop, load, loadBcd, countDown,
    output secPassed, secondsBcd, expired, expiredPulse, running, warn
  );
endinterface

// File: rtl/frame_game_timer.sv
// Frame-driven BCD seconds timer (up/down, load, pause, expiry); all outputs registered, 1-cycle latency.
// Optional low-time warning output is built only when FRAME_GAME_TIMER_WARN_EN is defined.
module frame_game_timer #(
  parameter int unsigned FPS      = 60,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned WARN_SEC = 10
) (
  input  logic                clk,
  input  logic                resetN,
  frame_game_timer_if.slave   bus
);

  localparam int unsigned    FCW        = $clog2(FPS);
  localparam int unsigned    BW         = 4 * DIGITS;
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(FPS - 1);
  localparam logic [BW-1:0]  BCD_ONE    = BW'(1);

  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0]  secs_q, secs_d;
  logic           sec_pulse_q, sec_pulse_d;
  logic           exp_pulse_q, exp_pulse_d;
  logic           running_q, expired_q;
  logic           counted;

  assign counted = (state_q == RUNNING) && !bus.pause && bus.startOfFrame;

  // Commands outrank a coincident frame: a frame landing with load/stop is dropped.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    secs_d      = secs_q;
    sec_pulse_d = 1'b0;
    exp_pulse_d = 1'b0;
    if (bus.load) begin
      state_d     = STOPPED;
      frame_cnt_d = '0;
      secs_d      = bus.loadBcd;
    end else if (bus.stop && state_q == RUNNING) begin
      state_d = STOPPED;
    end else if (bus.start && state_q == STOPPED) begin
      if (bus.countDown && secs_q == '0) begin
        state_d     = EXPIRED;
        exp_pulse_d = 1'b1;
      end else begin
        state_d = RUNNING;
      end
    end else if (counted) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        sec_pulse_d = 1'b1;
        if (bus.countDown) begin
          secs_d = bcd_dec(secs_q);
          if (secs_q == BCD_ONE) begin
            state_d     = EXPIRED;
            exp_pulse_d = 1'b1;
          end
        end else begin
          secs_d = bcd_inc(secs_q);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= STOPPED;
      frame_cnt_q <= '0;
      secs_q      <= '0;
      sec_pulse_q <= 1'b0;
      exp_pulse_q <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      secs_q      <= secs_d;
      sec_pulse_q <= sec_pulse_d;
      exp_pulse_q <= exp_pulse_d;
      running_q   <= (state_d == RUNNING);
      expired_q   <= (state_d == EXPIRED);
    end
  end

`ifdef FRAME_GAME_TIMER_WARN_EN
  function automatic int unsigned bcd_to_bin(input logic [BW-1:0] v);
    int unsigned acc;
    acc = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      acc = acc * 32'd10 + 32'(v[4*i +: 4]);
    end
    return acc;
  endfunction

  int unsigned secs_bin_d;
  logic        warn_d, warn_q;

  // Judged on the next value so warn moves in the same cycle as secondsBcd.
  always_comb begin
    secs_bin_d = bcd_to_bin(secs_d);
    warn_d     = (state_d == RUNNING) && bus.countDown &&
                 (secs_bin_d != 0) && (secs_bin_d <= WARN_SEC);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign bus.warn = warn_q;
`else
  logic unused_warn_sec;
  assign unused_warn_sec = WARN_SEC[0];
  assign bus.warn        = 1'b0;
`endif

  assign bus.secPassed    = sec_pulse_q;
  assign bus.secondsBcd   = secs_q;
  assign bus.expired      = expired_q;
  assign bus.expiredPulse = exp_pulse_q;
  assign bus.running      = running_q;

endmodule
